// File: rtl/ppu_bg_line_fetcher.sv
// Background scanline fetcher: map/lo/hi VRAM reads per tile, then one 2-bit pixel per cycle.
// Optional PPU_BG_PALETTE_EN maps raw colour indices through the latched BGP register.
//
// state | meaning
// IDLE  | waiting for start
// MAP   | reading tile-map entry (VRAM_LATENCY cycles)
// LO    | reading low bit-plane byte (VRAM_LATENCY cycles)
// HI    | reading high bit-plane byte (VRAM_LATENCY cycles)
// PUSH  | emitting one pixel per cycle from the fetched tile
// DONE  | one-cycle completion pulse
module ppu_bg_line_fetcher #(
  parameter int LINE_PIXELS  = 160,
  parameter int VRAM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  ly,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  bgp,
  input  logic        map_sel,
  input  logic        data_sel,
  output logic [15:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [1:0]  pix_color,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_LO, S_HI, S_PUSH, S_DONE
  } state_t;

  localparam logic [1:0] LAT_LOAD = 2'(VRAM_LATENCY - 1);
  localparam logic [7:0] LAST_X   = 8'(LINE_PIXELS - 1);

  state_t      state_q, state_d;
  logic [1:0]  lat_q;
  logic [5:0]  tile_q;
  logic [2:0]  bit_q;
  logic [7:0]  idx_q, lo_q, hi_q;
  logic [7:0]  scx_q, bgy_q;
  logic        map_sel_q, data_sel_q;
  logic [7:0]  cnt_q;
  logic        pix_we_q;
  logic [7:0]  pix_x_q;
  logic [1:0]  pix_color_q;

  logic        accept, lat_tc;
  logic [4:0]  tx;
  logic [15:0] map_addr, data_addr;
  logic [2:0]  start_bit, push_bit;
  logic [7:0]  hi_src;
  logic [1:0]  raw_d, color_d;
  logic        pix_we_d;

`ifdef PPU_BG_PALETTE_EN
  logic [7:0]  bgp_q;
`else
  logic        unused_bgp;
  assign unused_bgp = ^bgp;
`endif

  assign accept = (state_q == S_IDLE) && start && !abort;
  assign lat_tc = (lat_q == 2'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start)  state_d = S_MAP;
        S_MAP:  if (lat_tc) state_d = S_LO;
        S_LO:   if (lat_tc) state_d = S_HI;
        S_HI:   if (lat_tc) state_d = S_PUSH;
        S_PUSH: begin
          if (pix_x_q == LAST_X) state_d = S_DONE;
          else if (bit_q == 3'd0) state_d = S_MAP;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: VRAM port and status decode from state; next pixel values for the pixel registers.
  always_comb begin
    tx        = scx_q[7:3] + tile_q[4:0];
    map_addr  = {5'b10011, map_sel_q, bgy_q[7:3], tx};
    // Signed mode: idx[7]=0 lands at 0x9000+, idx[7]=1 at 0x8800..0x8FF0.
    data_addr = {3'b100, data_sel_q ? 1'b0 : ~idx_q[7], idx_q, bgy_q[2:0], 1'b0};
    vram_rd   = 1'b0;
    vram_addr = 16'h0000;
    case (state_q)
      S_MAP: begin vram_rd = 1'b1; vram_addr = map_addr; end
      S_LO:  begin vram_rd = 1'b1; vram_addr = data_addr; end
      S_HI:  begin vram_rd = 1'b1; vram_addr = {data_addr[15:1], 1'b1}; end
      default: ;
    endcase
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);

    start_bit = (tile_q == 6'd0) ? ~scx_q[2:0] : 3'd7;
    push_bit  = (state_q == S_HI) ? start_bit : bit_q - 3'd1;
    hi_src    = (state_q == S_HI) ? vram_data : hi_q;
    raw_d     = {hi_src[push_bit], lo_q[push_bit]};
    pix_we_d  = (state_d == S_PUSH);
`ifdef PPU_BG_PALETTE_EN
    color_d   = bgp_q[{raw_d, 1'b0} +: 2];
`else
    color_d   = raw_d;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_q       <= 2'd0;
      tile_q      <= 6'd0;
      bit_q       <= 3'd0;
      idx_q       <= 8'h00;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      scx_q       <= 8'h00;
      bgy_q       <= 8'h00;
      map_sel_q   <= 1'b0;
      data_sel_q  <= 1'b0;
      cnt_q       <= 8'h00;
      pix_we_q    <= 1'b0;
      pix_x_q     <= 8'h00;
      pix_color_q <= 2'b00;
`ifdef PPU_BG_PALETTE_EN
      bgp_q       <= 8'h00;
`endif
    end else begin
      if (state_d != state_q)  lat_q <= LAT_LOAD;
      else if (!lat_tc)        lat_q <= lat_q - 2'd1;

      if (accept) begin
        scx_q      <= scx;
        bgy_q      <= ly + scy;
        map_sel_q  <= map_sel;
        data_sel_q <= data_sel;
        tile_q     <= 6'd0;
        cnt_q      <= 8'h00;
`ifdef PPU_BG_PALETTE_EN
        bgp_q      <= bgp;
`endif
      end

      if (state_q == S_MAP && lat_tc) idx_q <= vram_data;
      if (state_q == S_LO  && lat_tc) lo_q  <= vram_data;
      if (state_q == S_HI  && lat_tc) begin
        hi_q  <= vram_data;
        bit_q <= start_bit;
      end
      if (state_q == S_PUSH) begin
        bit_q <= bit_q - 3'd1;
        if (state_d == S_MAP) tile_q <= tile_q + 6'd1;
      end

      pix_we_q <= pix_we_d;
      if (pix_we_d) begin
        pix_x_q     <= cnt_q;
        pix_color_q <= color_d;
        cnt_q       <= cnt_q + 8'd1;
      end
    end
  end

  assign pix_we    = pix_we_q;
  assign pix_x     = pix_x_q;
  assign pix_color = pix_color_q;

endmodule
